fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_pkg.sv | 17 +
 rtl/booth_r4_pp.sv | 30 +++
 rtl/fp_mul_seq.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
package fp_mul_pkg;
  typedef enum logic [1:0] {IDLE, BOOTH, NORM_RND, DONE} state_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_t;

  localparam int          EXP_BIAS    = 127;
  localparam logic [31:0] QNAN        = 32'h7FC00000;
  localparam logic [30:0] MAX_FIN     = 31'h7F7FFFFF;
  localparam int          BOOTH_STEPS = 13;
endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product selector: one 3-bit multiplier group picks
// 0, +-X or +-2X, returned as a 48-bit two's-complement value shifted by 2*idx.
module booth_r4_pp (
  input  logic [2:0]  grp,
  input  logic [23:0] mant_x,
  input  logic [3:0]  idx,
  output logic [47:0] pp
);
  logic [47:0] mag;
  logic        neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (grp)
      3'b001, 3'b010: mag = {24'b0, mant_x};
      3'b011:         mag = {23'b0, mant_x, 1'b0};
      3'b100: begin
        mag = {23'b0, mant_x, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {24'b0, mant_x};
        neg = 1'b1;
      end
      default: ;
    endcase
    pp = (neg ? (~mag + 48'd1) : mag) << {idx, 1'b0};
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier: 13-step radix-4 Booth core, then one
// normalize/round cycle. FP_MUL_SEQ_FULLPROD_EN adds the frc_Z_full output.
module fp_mul_seq
  import fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output state_t      fsm_state
`ifdef FP_MUL_SEQ_FULLPROD_EN
  ,output logic [47:0] frc_Z_full
`endif
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready only in IDLE, out_valid only in DONE, so they never coincide.
  state_t      state, state_nx;
  logic [3:0]  step;
  logic [47:0] prod, pp;
  logic [23:0] mant_x, mant_y;
  logic [7:0]  exp_x, exp_y;
  logic        sign_z;
  rmode_t      rm;
  logic [26:0] mplr;
  logic        accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign mplr      = {2'b00, mant_y, 1'b0};

  // Operand classification straight off the inputs, used only at accept.
  logic x_max, y_max, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special;
  logic [31:0] special_z;
  assign x_max   = &fp_X[30:23];
  assign y_max   = &fp_Y[30:23];
  assign x_nan   = x_max & (|fp_X[22:0]);
  assign y_nan   = y_max & (|fp_Y[22:0]);
  assign x_inf   = x_max & ~(|fp_X[22:0]);
  assign y_inf   = y_max & ~(|fp_Y[22:0]);
  assign x_zero  = ~(|fp_X[30:23]);
  assign y_zero  = ~(|fp_Y[30:23]);
  assign special = x_max | y_max | x_zero | y_zero;

  always_comb begin
    special_z = {fp_X[31] ^ fp_Y[31], 31'b0};
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      special_z = QNAN;
    else if (x_inf || y_inf)
      special_z = {fp_X[31] ^ fp_Y[31], 8'hFF, 23'b0};
  end

  booth_r4_pp u_pp (
    .grp    (mplr[{step, 1'b0} +: 3]),
    .mant_x (mant_x),
    .idx    (step),
    .pp     (pp)
  );

  // Normalize, round and range-check the finished product.
  logic               norm, guard, sticky, inc, carry;
  logic [22:0]        frac_t, frac_r;
  logic [24:0]        sum;
  logic signed [9:0]  exp_pre, exp_r;
  logic               ovf, unf;
  logic [31:0]        ovf_z, rnd_z;

  always_comb begin
    norm    = prod[47];
    frac_t  = norm ? prod[46:24] : prod[45:23];
    guard   = norm ? prod[23] : prod[22];
    sticky  = norm ? |prod[22:0] : |prod[21:0];
    case (rm)
      RM_RNE:  inc = guard & (sticky | frac_t[0]);
      RM_RDN:  inc = sign_z & (guard | sticky);
      RM_RUP:  inc = ~sign_z & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = 1'b0;
    endcase
    sum     = {2'b01, frac_t} + {24'b0, inc};
    carry   = sum[24];
    frac_r  = carry ? sum[23:1] : sum[22:0];
    exp_pre = {2'b00, exp_x} + {2'b00, exp_y} - 10'(EXP_BIAS) + {9'b0, norm};
    exp_r   = exp_pre + {9'b0, carry};
    ovf     = (exp_r >= 10'sd255);
    unf     = (exp_r <= 10'sd0);
    case (rm)
      RM_RTZ:  ovf_z = {sign_z, MAX_FIN};
      RM_RDN:  ovf_z = sign_z ? {1'b1, 8'hFF, 23'b0} : {1'b0, MAX_FIN};
      RM_RUP:  ovf_z = sign_z ? {1'b1, MAX_FIN} : {1'b0, 8'hFF, 23'b0};
      default: ovf_z = {sign_z, 8'hFF, 23'b0};
    endcase
    if (ovf)      rnd_z = ovf_z;
    else if (unf) rnd_z = {sign_z, 31'b0};
    else          rnd_z = {sign_z, exp_r[7:0], frac_r};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = special ? DONE : BOOTH;
      BOOTH:    if (step == 4'(BOOTH_STEPS - 1)) state_nx = NORM_RND;
      NORM_RND: state_nx = DONE;
      DONE:     if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step   <= '0;
      prod   <= '0;
      fp_Z   <= '0;
      ovrf   <= 1'b0;
      udrf   <= 1'b0;
      mant_x <= '0;
      mant_y <= '0;
      exp_x  <= '0;
      exp_y  <= '0;
      sign_z <= 1'b0;
      rm     <= RM_RNE;
`ifdef FP_MUL_SEQ_FULLPROD_EN
      frc_Z_full <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          mant_x <= {1'b1, fp_X[22:0]};
          mant_y <= {1'b1, fp_Y[22:0]};
          exp_x  <= fp_X[30:23];
          exp_y  <= fp_Y[30:23];
          sign_z <= fp_X[31] ^ fp_Y[31];
          rm     <= (r_mode > 3'd4) ? RM_RNE : rmode_t'(r_mode);
          step   <= '0;
          prod   <= '0;
          if (special) begin
            fp_Z <= special_z;
            ovrf <= 1'b0;
            udrf <= 1'b0;
`ifdef FP_MUL_SEQ_FULLPROD_EN
            frc_Z_full <= '0;
`endif
          end
        end
        BOOTH: begin
          prod <= prod + pp;
          step <= (step == 4'(BOOTH_STEPS - 1)) ? 4'd0 : step + 4'd1;
        end
        NORM_RND: begin
          fp_Z <= rnd_z;
          ovrf <= ovf;
          udrf <= unf & ~ovf;
`ifdef FP_MUL_SEQ_FULLPROD_EN
          frc_Z_full <= prod;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed corner table plus random operands
// checked against an arithmetic reference model, with backpressure and aborts.
module tb_fp_mul_seq;
  import fp_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_X = '0;
  logic [31:0] fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf, udrf;
  state_t      fsm_state;
`ifdef FP_MUL_SEQ_FULLPROD_EN
  logic [47:0] frc_Z_full;
`endif

  fp_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .fsm_state (fsm_state)
`ifdef FP_MUL_SEQ_FULLPROD_EN
    ,.frc_Z_full (frc_Z_full)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int hold_cycles = -1;

  logic [33:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] rm_in);
    logic s;
    int ex, ey, e, m, sh;
    longint unsigned mx, my, p, q, rem, half;
    bit up, nan_x, nan_y, inf_x, inf_y, zer_x, zer_y;
    logic [7:0] e8;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nan_x = (ex == 255) && (x[22:0] != 0);
    nan_y = (ey == 255) && (y[22:0] != 0);
    inf_x = (ex == 255) && (x[22:0] == 0);
    inf_y = (ey == 255) && (y[22:0] == 0);
    zer_x = (ex == 0);
    zer_y = (ey == 0);
    if (nan_x || nan_y || (inf_x && zer_y) || (inf_y && zer_x)) return {32'h7FC00000, 2'b00};
    if (inf_x || inf_y) return {s, 8'hFF, 23'h0, 2'b00};
    if (zer_x || zer_y) return {s, 31'h0, 2'b00};
    mx = 64'(x[22:0]) + 64'h800000;
    my = 64'(y[22:0]) + 64'h800000;
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin e++; sh = 24; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    m    = (rm_in > 3'd4) ? 0 : int'(rm_in);
    case (m)
      0:       up = (rem > half) || ((rem == half) && q[0]);
      1:       up = 1'b0;
      2:       up = s && (rem != 0);
      3:       up = !s && (rem != 0);
      default: up = (rem >= half);
    endcase
    q = q + 64'(up);
    if (q == 64'h100_0000) begin q = 64'h80_0000; e++; end
    if (e >= 255) begin
      case (m)
        1:       return {s, 31'h7F7FFFFF, 2'b10};
        2:       return s ? {1'b1, 8'hFF, 23'h0, 2'b10} : {1'b0, 31'h7F7FFFFF, 2'b10};
        3:       return s ? {1'b1, 31'h7F7FFFFF, 2'b10} : {1'b0, 8'hFF, 23'h0, 2'b10};
        default: return {s, 8'hFF, 23'h0, 2'b10};
      endcase
    end
    if (e <= 0) return {s, 31'h0, 2'b01};
    e8 = e[7:0];
    return {s, e8, q[22:0], 2'b00};
  endfunction

  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF)
      return 1;
    return 15;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                       input logic [33:0] expv, input bit track);
    int guard_n = 0;
    @(negedge clk);
    while (!in_ready && guard_n < 300) begin
      @(negedge clk);
      guard_n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) begin
      exp_q.push_back(expv);
      lat_q.push_back(ref_lat(x, y));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 600) begin
      @(negedge clk);
      g++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_v;
    logic [33:0] held, e;
    int          hold_left, lat, acc;
    prev_v = 1'b0;
    hold_left = 0;
    held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          held = {fp_Z, ovrf, udrf};
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e   = exp_q.pop_front();
            lat = lat_q.pop_front();
            acc = acc_q.pop_front();
            check("fp_Z", 64'(fp_Z), 64'(e[33:2]));
            check("ovrf", 64'(ovrf), 64'(e[1]));
            check("udrf", 64'(udrf), 64'(e[0]));
            check("latency", 64'(cyc - acc + 1), 64'(lat));
          end
          hold_left = (hold_cycles >= 0) ? hold_cycles : int'($urandom_range(0, 3));
          out_ready = (hold_left == 0);
        end else if (out_valid) begin
          check("hold_stable", 64'({fp_Z, ovrf, udrf}), 64'(held));
          check("hold_in_ready", 64'(in_ready), 64'd0);
          if (hold_left > 0) hold_left--;
          out_ready = (hold_left == 0);
        end else begin
          out_ready = 1'b0;
        end
        prev_v = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [33:0] e;
  } vec_t;

  vec_t dir_tab[16];

  function automatic logic [31:0] rand_op();
    int cls;
    logic [7:0] ex;
    cls = int'($urandom_range(0, 9));
    case (cls)
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      2:       ex = 8'(int'($urandom_range(230, 254)));
      3:       ex = 8'(int'($urandom_range(1, 30)));
      default: ex = 8'(int'($urandom_range(100, 154)));
    endcase
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] x, y;
    logic [2:0]  rm;
    dir_tab[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, {32'h40400000, 2'b00}};
    dir_tab[1]  = '{32'h00000000, 32'hC0000000, 3'd0, {32'h80000000, 2'b00}};
    dir_tab[2]  = '{32'h00000001, 32'h3F800000, 3'd0, {32'h00000000, 2'b00}};
    dir_tab[3]  = '{32'h7F800000, 32'h00000000, 3'd0, {32'h7FC00000, 2'b00}};
    dir_tab[4]  = '{32'h7F000000, 32'h7F000000, 3'd0, {32'h7F800000, 2'b10}};
    dir_tab[5]  = '{32'h7F000000, 32'h7F000000, 3'd1, {32'h7F7FFFFF, 2'b10}};
    dir_tab[6]  = '{32'h00800000, 32'h00800000, 3'd0, {32'h00000000, 2'b01}};
    dir_tab[7]  = '{32'h3F800001, 32'h3F800001, 3'd0, {32'h3F800002, 2'b00}};
    dir_tab[8]  = '{32'h3F800001, 32'h3F800001, 3'd3, {32'h3F800003, 2'b00}};
    dir_tab[9]  = '{32'h3F800001, 32'h3F800001, 3'd1, {32'h3F800002, 2'b00}};
    dir_tab[10] = '{32'hFF000000, 32'h7F000000, 3'd2, {32'hFF800000, 2'b10}};
    dir_tab[11] = '{32'hFF000000, 32'h7F000000, 3'd3, {32'hFF7FFFFF, 2'b10}};
    dir_tab[12] = '{32'h7F800000, 32'hC0000000, 3'd0, {32'hFF800000, 2'b00}};
    dir_tab[13] = '{32'h7FC00001, 32'h3F800000, 3'd4, {32'h7FC00000, 2'b00}};
    dir_tab[14] = '{32'h3F800001, 32'h3F800001, 3'd7, {32'h3F800002, 2'b00}};
    dir_tab[15] = '{32'hBF800001, 32'h3F800001, 3'd2, {32'hBF800003, 2'b00}};

    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fp_Z", 64'(fp_Z), 64'd0);
    check("rst_flags", 64'({ovrf, udrf}), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(IDLE));

    // directed corners
    for (int i = 0; i < 16; i++)
      issue(dir_tab[i].x, dir_tab[i].y, dir_tab[i].rm, dir_tab[i].e, 1'b1);
    drain();

    // output held for 5 cycles of backpressure
    hold_cycles = 5;
    issue(32'h3FC00000, 32'h40000000, 3'd0, {32'h40400000, 2'b00}, 1'b1);
    drain();
    issue(32'h80000000, 32'h3F800000, 3'd0, {32'h80000000, 2'b00}, 1'b1);
    drain();
    hold_cycles = -1;

    // in_valid while busy must be ignored
    issue(32'h40400000, 32'h40A00000, 3'd0, {32'h41700000, 2'b00}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("busy_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      fp_X = $urandom;
      fp_Y = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // reset in the middle of BOOTH aborts the operation
    issue(32'h40400000, 32'h40400000, 3'd0, '0, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_state_booth", 64'(fsm_state), 64'(BOOTH));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_fp_Z", 64'(fp_Z), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_no_output", 64'(out_valid), 64'd0);

    // randomized operands against the model
    for (int n = 0; n < 70; n++) begin
      x  = rand_op();
      y  = rand_op();
      rm = 3'($urandom_range(0, 7));
      issue(x, y, rm, ref_mul(x, y, rm), 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
